stack_spill: RTL
================

STACK_SPILL -- requirements
Module: stack_spill

Interface
REQ-001 SHALL have parameter WIDTH, 32, element width in bits.
REQ-002 SHALL have parameter DEPTH, 4, on-chip entries (minimum 2).
REQ-003 SHALL have parameter VISIBLES, 1, top entries exposed (at most DEPTH).
REQ-004 SHALL have parameter LOW_WATER, 1, on-chip count at or below which refill starts (less than DEPTH-1).
REQ-005 SHALL have parameter MEM_DEPTH, 8, spill slots in memory.
REQ-006 SHALL have parameter ADDR_WIDTH, 16, memory address width; SPILL_BASE, 0, address of spill slot 0.
REQ-007 SHALL have parameter BOTTOM, all-zero, value shown for empty positions.
REQ-008 SHALL use one clock and a synchronous, active-high reset, declared as: clk input 1 (rising-edge clock); reset input 1 (synchronous, active-high).
REQ-009 SHALL have ports: push input 1; pop input 1; insert input WIDTH; tops output VISIBLES x WIDTH; busy output 1 (push/pop ignored).
REQ-010 SHALL have ports: overflow output 1 (one-cycle pulse); underflow output 1 (one-cycle pulse).
REQ-011 SHALL have ports: mem_addr output ADDR_WIDTH; mem_wr_data output WIDTH; mem_we output 1; mem_re output 1; mem_rd_data input WIDTH; mem_ack input 1 (one-cycle completion).

Function
REQ-012 SHALL keep on-chip count (0..DEPTH) and spill count (0..MEM_DEPTH); tops[i] SHALL equal entry i when i < count, else BOTTOM.
REQ-013 SHALL accept push/pop only in state IDLE with busy=0; busy SHALL be 1 in states SPILL and FILL.
REQ-014 When push and pop are both high and count>0, the top SHALL be replaced by insert, with counts unchanged and no memory access; with count=0 this SHALL act as a plain push.
REQ-015 On push alone with count<DEPTH, entries SHALL shift down, entry 0 SHALL become insert, and count SHALL increment, all in one cycle.
REQ-016 On push alone with count=DEPTH and spill count<MEM_DEPTH, the shift SHALL happen in the same cycle and the evicted bottom entry SHALL latch into mem_wr_data.
REQ-017 In that case the next cycle SHALL enter SPILL with mem_we=1 and mem_addr=SPILL_BASE+spill count.
REQ-018 On push alone with count=DEPTH and spill count=MEM_DEPTH, the push SHALL be dropped, overflow SHALL pulse, and state SHALL not change.
REQ-019 SPILL SHALL hold mem_addr, mem_wr_data and mem_we stable until mem_ack; on mem_ack it SHALL increment spill count, deassert mem_we and return to IDLE in the same cycle.
REQ-020 On pop alone with count>0, entries SHALL shift up, the vacated position SHALL show BOTTOM, and count SHALL decrement.
REQ-021 On pop alone with count=0, underflow SHALL pulse and no state SHALL change.
REQ-022 In IDLE with no accepted operation, count<=LOW_WATER and spill count>0, the next cycle SHALL enter FILL with mem_re=1 and mem_addr=SPILL_BASE+spill count-1.
REQ-023 FILL SHALL hold mem_addr and mem_re stable until mem_ack; on mem_ack, mem_rd_data SHALL be written to entry[count], count SHALL increment and spill count SHALL decrement.
REQ-024 On FILL completion the block SHALL return to IDLE, re-evaluating REQ-022 next cycle, so refill repeats until count>LOW_WATER or spill count=0.
REQ-025 An accepted push/pop SHALL take priority over starting FILL in the same cycle.
REQ-026 mem_ack seen in IDLE SHALL be ignored.
REQ-027 mem_we and mem_re SHALL never both be 1.

Reset
REQ-028 On reset the block SHALL set state IDLE, count 0, spill count 0, all tops BOTTOM, busy/mem_we/mem_re/overflow/underflow 0, and mem_addr/mem_wr_data 0.
REQ-029 Reset during SPILL or FILL SHALL abandon the transfer without waiting for mem_ack; a late mem_ack SHALL be ignored per REQ-026.

Structure
REQ-030 Package stack_spill_pkg SHALL hold the state enum (IDLE, SPILL, FILL).
REQ-031 On-chip storage SHALL be a per-entry loadable register array inside stack_spill; no sub-module is required.

Verification (DEPTH=4, LOW_WATER=1, MEM_DEPTH=8, SPILL_BASE=0x100)
REQ-032 Push 1,2,3,4,5 -> after the 5th push tops[0]=5; the next cycle gives mem_we=1, mem_addr=0x100, mem_wr_data=1, busy=1; ack after 3 cycles -> busy=0, spill count 1.
REQ-033 From REQ-032, pop x3 -> tops[0]=2 and count=1; FILL gives mem_re=1, mem_addr=0x100; return 1 -> entry1=1, count=2, spill count 0, IDLE.
REQ-034 Count=3 with tops[0]=7; push+pop with insert=9 -> tops[0]=9, count 3, no mem_we/mem_re.
REQ-035 Empty stack; pop -> underflow pulses for one cycle, tops[0]=BOTTOM; fill on-chip plus 8 spills, push -> overflow pulse, tops unchanged.
REQ-036 Reset asserted during SPILL before ack -> next cycle IDLE, mem_we=0, count 0; an ack 2 cycles later changes nothing.

Source files
------------

// File: rtl/stack_spill_pkg.sv
// Shared types for the spilling hardware stack.
// Holds the controller state encoding and the counter-width helper.
package stack_spill_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPILL = 2'd1,
        FILL  = 2'd2
    } state_t;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/stack_spill_if.sv
// Host and memory-side signals of the spilling stack, plus state/count observation.
// Handshake: push/pop are single-cycle requests honoured only while busy=0; mem_ack completes the held request.
interface stack_spill_if #(
    parameter int WIDTH      = 32,
    parameter int VISIBLES   = 1,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int MEM_DEPTH  = 8
);
    localparam int CW = stack_spill_pkg::cnt_w(DEPTH);
    localparam int SW = stack_spill_pkg::cnt_w(MEM_DEPTH);

    logic                           push;
    logic                           pop;
    logic [WIDTH-1:0]               insert;
    logic [VISIBLES-1:0][WIDTH-1:0] tops;
    logic                           busy;
    logic                           overflow;
    logic                           underflow;
    logic [ADDR_WIDTH-1:0]          mem_addr;
    logic [WIDTH-1:0]               mem_wr_data;
    logic                           mem_we;
    logic                           mem_re;
    logic [WIDTH-1:0]               mem_rd_data;
    logic                           mem_ack;
    stack_spill_pkg::state_t        dbg_state;
    logic [CW-1:0]                  dbg_count;
    logic [SW-1:0]                  dbg_spill;

    modport master (
        output push, pop, insert, mem_rd_data, mem_ack,
        input  tops, busy, overflow, underflow, mem_addr, mem_wr_data,
               mem_we, mem_re, dbg_state, dbg_count, dbg_spill
    );

    modport slave (
        input  push, pop, insert, mem_rd_data, mem_ack,
        output tops, busy, overflow, underflow, mem_addr, mem_wr_data,
               mem_we, mem_re, dbg_state, dbg_count, dbg_spill
    );

endinterface

// File: rtl/stack_spill.sv
// Register stack with the top DEPTH entries on chip; older entries spill to
// and refill from a memory region starting at SPILL_BASE.
module stack_spill
    import stack_spill_pkg::*;
#(
    parameter int                    WIDTH      = 32,
    parameter int                    DEPTH      = 4,
    parameter int                    VISIBLES   = 1,
    parameter int                    LOW_WATER  = 1,
    parameter int                    MEM_DEPTH  = 8,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] SPILL_BASE = '0,
    parameter logic [WIDTH-1:0]      BOTTOM     = '0
) (
    input  logic         clk,
    input  logic         reset,
    stack_spill_if.slave bus
);
    localparam int CW = cnt_w(DEPTH);
    localparam int SW = cnt_w(MEM_DEPTH);

    state_t                r_state;
    logic [WIDTH-1:0]      r_entries [DEPTH];
    logic [CW-1:0]         r_count;
    logic [SW-1:0]         r_spill;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [WIDTH-1:0]      r_wr_data;
    logic                  r_we;
    logic                  r_re;
    logic                  r_ovf;
    logic                  r_unf;

    logic w_idle;
    logic w_full;
    logic w_replace;
    logic w_push_only;
    logic w_pop_only;
    logic w_shift_down;
    logic w_start_spill;
    logic w_start_fill;

    always_comb begin
        w_idle        = (r_state == IDLE);
        w_full        = (r_count == CW'(DEPTH));
        w_replace     = w_idle && bus.push && bus.pop && (r_count != '0);
        w_push_only   = w_idle && bus.push && !w_replace;
        w_pop_only    = w_idle && bus.pop && !bus.push;
        w_start_spill = w_push_only && w_full && (r_spill < SW'(MEM_DEPTH));
        w_shift_down  = w_push_only && (!w_full || w_start_spill);
        // Host operations win over refill in the same cycle.
        w_start_fill  = w_idle && !bus.push && !bus.pop &&
                        (r_count <= CW'(LOW_WATER)) && (r_spill != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_spill    <= '0;
            r_mem_addr <= '0;
            r_wr_data  <= '0;
            r_we       <= 1'b0;
            r_re       <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_entries[i] <= BOTTOM;
        end else begin
            r_ovf <= w_push_only && w_full && !w_start_spill;
            r_unf <= w_pop_only && (r_count == '0);

            if (w_replace) r_entries[0] <= bus.insert;

            if (w_shift_down) begin
                for (int i = 1; i < DEPTH; i++) r_entries[i] <= r_entries[i-1];
                r_entries[0] <= bus.insert;
                if (!w_full) r_count <= r_count + CW'(1);
            end

            if (w_pop_only && (r_count != '0)) begin
                for (int i = 0; i < DEPTH - 1; i++) r_entries[i] <= r_entries[i+1];
                r_entries[DEPTH-1] <= BOTTOM;
                r_count <= r_count - CW'(1);
            end

            case (r_state)
                IDLE: begin
                    if (w_start_spill) begin
                        r_wr_data  <= r_entries[DEPTH-1];
                        r_mem_addr <= SPILL_BASE + ADDR_WIDTH'(r_spill);
                        r_we       <= 1'b1;
                        r_state    <= SPILL;
                    end else if (w_start_fill) begin
                        r_mem_addr <= SPILL_BASE + ADDR_WIDTH'(r_spill) - ADDR_WIDTH'(1);
                        r_re       <= 1'b1;
                        r_state    <= FILL;
                    end
                end
                SPILL: begin
                    if (bus.mem_ack) begin
                        r_spill <= r_spill + SW'(1);
                        r_we    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                FILL: begin
                    if (bus.mem_ack) begin
                        // Refilled word lands just below the current on-chip entries.
                        for (int i = 0; i < DEPTH; i++)
                            if (CW'(i) == r_count) r_entries[i] <= bus.mem_rd_data;
                        r_count <= r_count + CW'(1);
                        r_spill <= r_spill - SW'(1);
                        r_re    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < VISIBLES; i++)
            bus.tops[i] = (CW'(i) < r_count) ? r_entries[i] : BOTTOM;
    end

    assign bus.busy        = (r_state != IDLE);
    assign bus.overflow    = r_ovf;
    assign bus.underflow   = r_unf;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wr_data = r_wr_data;
    assign bus.mem_we      = r_we;
    assign bus.mem_re      = r_re;
    assign bus.dbg_state   = r_state;
    assign bus.dbg_count   = r_count;
    assign bus.dbg_spill   = r_spill;

endmodule
